// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame FSM state encoding used by both the
// transmitter and receiver, plus default frame parameters.
package uart_pkg;

   typedef enum logic [1:0] {Idle, Start, Data, Stop} uart_state_t;

   localparam int UART_OVERSAMPLE_DEFAULT = 16;
   localparam int UART_DATA_BITS_DEFAULT  = 8;

   // Counter width for a modulo-n count, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and oversample tick in, received
// word with its strobe and status out.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS_DEFAULT
) ();

   logic                 rx;
   logic                 enb;
   logic [DATA_BITS-1:0] data_out;
   logic                 rx_done;
   logic                 frame_err;
   logic                 busy;

   // The receiver consumes the line and tick and reports the word.
   modport slave (
      input  rx, enb,
      output data_out, rx_done, frame_err, busy
   );

   modport master (
      output rx, enb,
      input  data_out, rx_done, frame_err, busy
   );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value
// matches the idle level of the signal being synchronised.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: flops are written with <= so every register samples pre-edge values;
   // blocking = here would collapse the two stages into one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: edge-detected start bit validated at mid-bit, LSB-first data
// sampled at mid-bit, stop bit checked and reported with a one-cycle strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
   input  logic     clk,
   input  logic     reset_n,
   uart_rx_if.slave bus
);

   localparam int TICK_W = width_of(OVERSAMPLE);
   localparam int BIT_W  = width_of(DATA_BITS);

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   logic rx_s;

   uart_state_t          state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.rx),
      .q       (rx_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= Idle;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;

      unique case (state_q)
         Idle: begin
            if (!rx_s) begin
               state_d = Start;
               tick_d  = '0;
            end
         end
         Start: begin
            if (bus.enb) begin
               if (tick_q == TICK_MID) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  // A start bit that is high again at mid-bit was a glitch.
                  state_d = rx_s ? Idle : Data;
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
         end
         Data: begin
            if (bus.enb) begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_LAST) state_d = Stop;
                  else                   bit_d   = bit_q + BIT_ONE;
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
         end
         Stop: begin
            if (bus.enb) begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  data_d  = shreg_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
                  // Leaving at mid stop bit keeps a back-to-back start edge visible.
                  state_d = Idle;
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
         end
         default: state_d = Idle;
      endcase
   end

   assign bus.data_out  = data_q;
   assign bus.rx_done   = done_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != Idle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit-serially, expected
// words are queued at send time and compared when rx_done pulses.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int DB = 8;
   localparam int OS = 16;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          ferr;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   uart_rx_if #(.DATA_BITS(DB)) bus ();

   uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;
   int   enb_div  = 4;
   int   base;
   logic done_prev = 1'b0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Oversample tick: one-cycle pulse every enb_div clocks.
   initial begin : enb_gen
      int ph;
      ph      = 0;
      bus.enb = 1'b0;
      forever begin
         @(negedge clk);
         bus.enb = (ph == 0);
         ph      = (ph + 1 >= enb_div) ? 0 : ph + 1;
      end
   end

   // Scoreboard consumer and strobe-width check.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (done_prev) check("done_width", {31'd0, bus.rx_done}, 32'd0);
         if (bus.rx_done) begin
            done_cnt++;
            check("sb_expect", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("data_out", {24'd0, bus.data_out}, {24'd0, mon_e.data});
               check("frame_err", {31'd0, bus.frame_err}, {31'd0, mon_e.ferr});
            end
         end
         done_prev = bus.rx_done;
      end
   end

   task automatic drive_bit(input logic b, input int n);
      bus.rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive_bit(1'b1, n);
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic stop_val, input int stop_clks);
      int bc;
      bc = OS * enb_div;
      drive_bit(1'b0, bc);
      for (int i = 0; i < DB; i++) drive_bit(d[i], bc);
      drive_bit(stop_val, stop_clks);
   endtask

   initial begin : main
      int bc;
      logic [DB-1:0] partial;
      bus.rx  = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.rx_done}, 32'd0);
      check("rst_data", {24'd0, bus.data_out}, 32'd0);
      check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
      reset_n = 1'b1;
      idle(20);
      bc = OS * enb_div;

      // 1: single good frame
      base = done_cnt;
      sb.push_back('{data: 8'hA5, ferr: 1'b0});
      send_frame(8'hA5, 1'b1, bc);
      idle(bc);
      check("t1_pulses", done_cnt - base, 32'd1);
      check("t1_busy", {31'd0, bus.busy}, 32'd0);
      check("t1_drained", sb.size(), 32'd0);

      // 2: back-to-back frames with no idle gap
      base = done_cnt;
      sb.push_back('{data: 8'h00, ferr: 1'b0});
      sb.push_back('{data: 8'hFF, ferr: 1'b0});
      send_frame(8'h00, 1'b1, bc);
      send_frame(8'hFF, 1'b1, bc);
      idle(bc);
      check("t2_pulses", done_cnt - base, 32'd2);
      check("t2_drained", sb.size(), 32'd0);

      // 3: start glitch of 3 ticks is rejected at mid start bit
      base = done_cnt;
      drive_bit(1'b0, 3 * enb_div);
      check("t3_busy_rise", {31'd0, bus.busy}, 32'd1);
      idle(bc);
      check("t3_busy_fall", {31'd0, bus.busy}, 32'd0);
      check("t3_pulses", done_cnt - base, 32'd0);
      check("t3_data_held", {24'd0, bus.data_out}, 32'hFF);

      // 4: low stop bit flags a framing error; the line returns high before
      // the end of the stop period so the re-entered Start sees a glitch.
      base = done_cnt;
      sb.push_back('{data: 8'h3C, ferr: 1'b1});
      send_frame(8'h3C, 1'b0, (3 * bc) / 4);
      idle(2 * bc);
      check("t4_pulses_err", done_cnt - base, 32'd1);
      check("t4_ferr_held", {31'd0, bus.frame_err}, 32'd1);
      base = done_cnt;
      sb.push_back('{data: 8'h11, ferr: 1'b0});
      send_frame(8'h11, 1'b1, bc);
      idle(bc);
      check("t4_pulses_ok", done_cnt - base, 32'd1);
      check("t4_ferr_clear", {31'd0, bus.frame_err}, 32'd0);

      // 5: async reset in the middle of data bit 4
      base    = done_cnt;
      partial = 8'hC3;
      drive_bit(1'b0, bc);
      for (int i = 0; i < 4; i++) drive_bit(partial[i], bc);
      drive_bit(partial[4], bc / 2);
      check("t5_busy_pre", {31'd0, bus.busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_rst_done", {31'd0, bus.rx_done}, 32'd0);
      check("t5_rst_data", {24'd0, bus.data_out}, 32'd0);
      check("t5_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
      bus.rx = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(bc);
      check("t5_no_pulse", done_cnt - base, 32'd0);
      sb.push_back('{data: 8'h5A, ferr: 1'b0});
      send_frame(8'h5A, 1'b1, bc);
      idle(bc);
      check("t5_pulses", done_cnt - base, 32'd1);

      // 6: enb every cycle, 16 clk per bit
      enb_div = 1;
      idle(20);
      bc   = OS * enb_div;
      base = done_cnt;
      sb.push_back('{data: 8'h81, ferr: 1'b0});
      send_frame(8'h81, 1'b1, bc);
      idle(4 * bc);
      check("t6_pulses", done_cnt - base, 32'd1);
      check("t6_busy", {31'd0, bus.busy}, 32'd0);

      check("sb_final_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
